// File: rtl/decode_execute_register_if.sv
// ID/EX bundle: decode-stage payload in, registered execute-stage payload out.
interface decode_execute_register_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned COUNT_WIDTH    = 16
);
    localparam int unsigned CONTROL_WIDTH = 9;

    // Decode-stage side
    logic                      id_valid;
    logic [DATA_WIDTH-1:0]     id_pc_plus4;
    logic [DATA_WIDTH-1:0]     id_read_data1;
    logic [DATA_WIDTH-1:0]     id_read_data2;
    logic [DATA_WIDTH-1:0]     id_extended_instruction;
    logic [REG_ADDR_WIDTH-1:0] id_rs;
    logic [REG_ADDR_WIDTH-1:0] id_rt;
    logic [REG_ADDR_WIDTH-1:0] id_rd;
    logic [CONTROL_WIDTH-1:0]  id_control;
    logic                      flush;
    logic                      hold;

    // Execute-stage side
    logic                      ex_valid;
    logic [DATA_WIDTH-1:0]     ex_pc_plus4;
    logic [DATA_WIDTH-1:0]     ex_read_data1;
    logic [DATA_WIDTH-1:0]     ex_read_data2;
    logic [DATA_WIDTH-1:0]     ex_extended_instruction;
    logic [REG_ADDR_WIDTH-1:0] ex_rs;
    logic [REG_ADDR_WIDTH-1:0] ex_rt;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic [CONTROL_WIDTH-1:0]  ex_control;
    logic                      stall_out;
    logic [COUNT_WIDTH-1:0]    load_use_count;
    logic [COUNT_WIDTH-1:0]    flush_count;

    // Pipeline control / decode driver
    modport master (
        output id_valid, id_pc_plus4, id_read_data1, id_read_data2,
               id_extended_instruction, id_rs, id_rt, id_rd, id_control,
               flush, hold,
        input  ex_valid, ex_pc_plus4, ex_read_data1, ex_read_data2,
               ex_extended_instruction, ex_rs, ex_rt, ex_rd, ex_control,
               stall_out, load_use_count, flush_count
    );

    // The ID/EX register itself
    modport slave (
        input  id_valid, id_pc_plus4, id_read_data1, id_read_data2,
               id_extended_instruction, id_rs, id_rt, id_rd, id_control,
               flush, hold,
        output ex_valid, ex_pc_plus4, ex_read_data1, ex_read_data2,
               ex_extended_instruction, ex_rs, ex_rt, ex_rd, ex_control,
               stall_out, load_use_count, flush_count
    );
endinterface

// File: rtl/decode_execute_register.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold
// handling and saturating bubble/flush event counters.
module decode_execute_register #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned COUNT_WIDTH    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    decode_execute_register_if.slave   bus
);
    localparam int unsigned CONTROL_WIDTH = 9;
    localparam int unsigned MEM_READ_BIT  = 2;

    typedef struct packed {
        logic                      valid;
        logic [DATA_WIDTH-1:0]     pc_plus4;
        logic [DATA_WIDTH-1:0]     read_data1;
        logic [DATA_WIDTH-1:0]     read_data2;
        logic [DATA_WIDTH-1:0]     extended_instruction;
        logic [REG_ADDR_WIDTH-1:0] rs;
        logic [REG_ADDR_WIDTH-1:0] rt;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [CONTROL_WIDTH-1:0]  control;
    } ex_entry_t;

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

    ex_entry_t              ex_q, ex_d;
    logic [COUNT_WIDTH-1:0] load_use_count_q, load_use_count_d;
    logic [COUNT_WIDTH-1:0] flush_count_q, flush_count_d;
    logic                   load_use_c;
    logic                   stall_c;

    // Hazard detect: a load in EX whose destination feeds the ID instruction.
    always_comb begin
        load_use_c = bus.id_valid & ex_q.valid & ex_q.control[MEM_READ_BIT]
                   & (ex_q.rt != '0)
                   & ((ex_q.rt == bus.id_rs) | (ex_q.rt == bus.id_rt))
                   & ~bus.flush;
        stall_c    = (load_use_c | bus.hold) & ~bus.flush;
    end

    // Next-state: flush > hold > load-use bubble > normal capture.
    always_comb begin
        ex_d             = ex_q;
        load_use_count_d = load_use_count_q;
        flush_count_d    = flush_count_q;

        if (bus.flush) begin
            ex_d = '0;
            if (flush_count_q != COUNT_MAX) begin
                flush_count_d = flush_count_q + COUNT_WIDTH'(1);
            end
        end else if (bus.hold) begin
            ex_d = ex_q;
        end else if (load_use_c) begin
            ex_d = '0;
            if (load_use_count_q != COUNT_MAX) begin
                load_use_count_d = load_use_count_q + COUNT_WIDTH'(1);
            end
        end else begin
            ex_d.valid                = bus.id_valid;
            ex_d.pc_plus4             = bus.id_pc_plus4;
            ex_d.read_data1           = bus.id_read_data1;
            ex_d.read_data2           = bus.id_read_data2;
            ex_d.extended_instruction = bus.id_extended_instruction;
            ex_d.rs                   = bus.id_rs;
            ex_d.rt                   = bus.id_rt;
            ex_d.rd                   = bus.id_rd;
            ex_d.control              = bus.id_control;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q             <= '0;
            load_use_count_q <= '0;
            flush_count_q    <= '0;
        end else begin
            ex_q             <= ex_d;
            load_use_count_q <= load_use_count_d;
            flush_count_q    <= flush_count_d;
        end
    end

    assign bus.ex_valid                = ex_q.valid;
    assign bus.ex_pc_plus4             = ex_q.pc_plus4;
    assign bus.ex_read_data1           = ex_q.read_data1;
    assign bus.ex_read_data2           = ex_q.read_data2;
    assign bus.ex_extended_instruction = ex_q.extended_instruction;
    assign bus.ex_rs                   = ex_q.rs;
    assign bus.ex_rt                   = ex_q.rt;
    assign bus.ex_rd                   = ex_q.rd;
    assign bus.ex_control              = ex_q.control;
    assign bus.stall_out               = stall_c;
    assign bus.load_use_count          = load_use_count_q;
    assign bus.flush_count             = flush_count_q;
endmodule

// File: tb/tb_decode_execute_register.sv
// Directed bench for the ID/EX register: vector table plus hand-written
// hold, saturation and asynchronous-reset sequences.
module tb_decode_execute_register;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 4;   // narrow counters so saturation is reachable quickly
    localparam int unsigned NV = 17;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    decode_execute_register_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();

    decode_execute_register #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [31:0]   pc;
        logic [31:0]   rd1;
        logic [31:0]   imm;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [8:0]    ctrl;
        logic          fl;
        logic          hd;
        logic          e_stall;
        logic          e_valid;
        logic [31:0]   e_pc;
        logic [31:0]   e_rd1;
        logic [31:0]   e_imm;
        logic [4:0]    e_rt;
        logic [8:0]    e_ctrl;
        logic [CW-1:0] e_lu;
        logic [CW-1:0] e_fl;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] rd1,
                         input logic [31:0] rd2, input logic [31:0] imm,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [8:0] ctrl, input logic fl, input logic hd);
        bus.id_valid                = v;
        bus.id_pc_plus4             = pc;
        bus.id_read_data1           = rd1;
        bus.id_read_data2           = rd2;
        bus.id_extended_instruction = imm;
        bus.id_rs                   = rs;
        bus.id_rt                   = rt;
        bus.id_rd                   = rd;
        bus.id_control              = ctrl;
        bus.flush                   = fl;
        bus.hold                    = hd;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 9'h0, 1'b0, 1'b0);

        //          v     pc        rd1     imm        rs    rt    ctrl    fl    hd  | stall valid pc      rd1     imm     rt    ctrl    lu    fl
        vecs[0]  = '{1'b1, 32'h104, 32'h11, 32'hF,  5'd3, 5'd4, 9'h041, 1'b0, 1'b0, 1'b0, 1'b1, 32'h104, 32'h11, 32'hF,  5'd4, 9'h041, 4'd0, 4'd0};
        vecs[1]  = '{1'b1, 32'h108, 32'h22, 32'h8,  5'd2, 5'd5, 9'h027, 1'b0, 1'b0, 1'b0, 1'b1, 32'h108, 32'h22, 32'h8,  5'd5, 9'h027, 4'd0, 4'd0};
        vecs[2]  = '{1'b1, 32'h10C, 32'h33, 32'h0,  5'd5, 5'd6, 9'h041, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,  32'h0,  5'd0, 9'h000, 4'd1, 4'd0};
        vecs[3]  = '{1'b1, 32'h10C, 32'h33, 32'h0,  5'd5, 5'd6, 9'h041, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10C, 32'h33, 32'h0,  5'd6, 9'h041, 4'd1, 4'd0};
        vecs[4]  = '{1'b1, 32'h110, 32'h44, 32'h4,  5'd1, 5'd0, 9'h027, 1'b0, 1'b0, 1'b0, 1'b1, 32'h110, 32'h44, 32'h4,  5'd0, 9'h027, 4'd1, 4'd0};
        vecs[5]  = '{1'b1, 32'h114, 32'h55, 32'h0,  5'd0, 5'd0, 9'h041, 1'b0, 1'b0, 1'b0, 1'b1, 32'h114, 32'h55, 32'h0,  5'd0, 9'h041, 4'd1, 4'd0};
        vecs[6]  = '{1'b1, 32'h118, 32'h66, 32'hC,  5'd1, 5'd7, 9'h027, 1'b0, 1'b0, 1'b0, 1'b1, 32'h118, 32'h66, 32'hC,  5'd7, 9'h027, 4'd1, 4'd0};
        vecs[7]  = '{1'b1, 32'h11C, 32'h77, 32'h0,  5'd2, 5'd7, 9'h041, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  32'h0,  5'd0, 9'h000, 4'd1, 4'd1};
        vecs[8]  = '{1'b1, 32'h11C, 32'h77, 32'h0,  5'd2, 5'd7, 9'h041, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11C, 32'h77, 32'h0,  5'd7, 9'h041, 4'd1, 4'd1};
        vecs[9]  = '{1'b1, 32'h120, 32'h88, 32'h10, 5'd3, 5'd8, 9'h027, 1'b0, 1'b0, 1'b0, 1'b1, 32'h120, 32'h88, 32'h10, 5'd8, 9'h027, 4'd1, 4'd1};
        vecs[10] = '{1'b1, 32'h124, 32'h99, 32'h0,  5'd8, 5'd1, 9'h041, 1'b0, 1'b1, 1'b1, 1'b1, 32'h120, 32'h88, 32'h10, 5'd8, 9'h027, 4'd1, 4'd1};
        vecs[11] = '{1'b1, 32'h128, 32'hAA, 32'h0,  5'd8, 5'd1, 9'h041, 1'b0, 1'b1, 1'b1, 1'b1, 32'h120, 32'h88, 32'h10, 5'd8, 9'h027, 4'd1, 4'd1};
        vecs[12] = '{1'b1, 32'h128, 32'hAA, 32'h0,  5'd8, 5'd1, 9'h041, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,  32'h0,  5'd0, 9'h000, 4'd2, 4'd1};
        vecs[13] = '{1'b1, 32'h128, 32'hAA, 32'h0,  5'd8, 5'd1, 9'h041, 1'b0, 1'b0, 1'b0, 1'b1, 32'h128, 32'hAA, 32'h0,  5'd1, 9'h041, 4'd2, 4'd1};
        vecs[14] = '{1'b0, 32'h12C, 32'hBB, 32'h5,  5'd1, 5'd2, 9'h027, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12C, 32'hBB, 32'h5,  5'd2, 9'h027, 4'd2, 4'd1};
        vecs[15] = '{1'b1, 32'h130, 32'hCC, 32'h0,  5'd2, 5'd3, 9'h041, 1'b0, 1'b0, 1'b0, 1'b1, 32'h130, 32'hCC, 32'h0,  5'd3, 9'h041, 4'd2, 4'd1};
        vecs[16] = '{1'b1, 32'h134, 32'hDD, 32'h0,  5'd3, 5'd3, 9'h041, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,  32'h0,  5'd0, 9'h000, 4'd2, 4'd2};

        // Reset state
        step();
        step();
        @(negedge clk);
        reset = 1'b0;
        chk("reset_valid",  32'(bus.ex_valid), 32'h0);
        chk("reset_ctrl",   32'(bus.ex_control), 32'h0);
        chk("reset_pc",     bus.ex_pc_plus4, 32'h0);
        chk("reset_lu",     32'(bus.load_use_count), 32'h0);
        chk("reset_fl",     32'(bus.flush_count), 32'h0);
        chk("reset_stall",  32'(bus.stall_out), 32'h0);
        @(posedge clk);
        #1;

        // Vector table
        for (int i = 0; i < int'(NV); i++) begin
            drive(vecs[i].v, vecs[i].pc, vecs[i].rd1, vecs[i].rd1 ^ 32'hFFFF_0000,
                  vecs[i].imm, vecs[i].rs, vecs[i].rt, 5'(vecs[i].rt + 5'd1),
                  vecs[i].ctrl, vecs[i].fl, vecs[i].hd);
            #1;
            chk($sformatf("v%0d_stall", i), 32'(bus.stall_out), 32'(vecs[i].e_stall));
            step();
            chk($sformatf("v%0d_valid", i), 32'(bus.ex_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_pc", i),    bus.ex_pc_plus4, vecs[i].e_pc);
            chk($sformatf("v%0d_rd1", i),   bus.ex_read_data1, vecs[i].e_rd1);
            chk($sformatf("v%0d_imm", i),   bus.ex_extended_instruction, vecs[i].e_imm);
            chk($sformatf("v%0d_rt", i),    32'(bus.ex_rt), 32'(vecs[i].e_rt));
            chk($sformatf("v%0d_ctrl", i),  32'(bus.ex_control), 32'(vecs[i].e_ctrl));
            chk($sformatf("v%0d_lu", i),    32'(bus.load_use_count), 32'(vecs[i].e_lu));
            chk($sformatf("v%0d_fl", i),    32'(bus.flush_count), 32'(vecs[i].e_fl));
        end

        // Full-field capture, then hold for 3 cycles with changing inputs
        drive(1'b1, 32'h200, 32'h1234, 32'h5678, 32'hFFFF_FFF0, 5'd9, 5'd10, 5'd11, 9'h0C3, 1'b0, 1'b0);
        step();
        chk("cap_rd2", bus.ex_read_data2, 32'h5678);
        chk("cap_rs",  32'(bus.ex_rs), 32'd9);
        chk("cap_rd",  32'(bus.ex_rd), 32'd11);
        chk("cap_imm", bus.ex_extended_instruction, 32'hFFFF_FFF0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'(32'h204 + 4 * k), 32'(k), 32'(k + 100), 32'(k + 7),
                  5'(k + 1), 5'(k + 2), 5'(k + 3), 9'h041, 1'b0, 1'b1);
            #1;
            chk($sformatf("hold%0d_stall", k), 32'(bus.stall_out), 32'h1);
            step();
            chk($sformatf("hold%0d_pc", k),  bus.ex_pc_plus4, 32'h200);
            chk($sformatf("hold%0d_rd2", k), bus.ex_read_data2, 32'h5678);
            chk($sformatf("hold%0d_rd", k),  32'(bus.ex_rd), 32'd11);
            chk($sformatf("hold%0d_ctrl", k), 32'(bus.ex_control), 32'h0C3);
        end
        drive(1'b1, 32'h210, 32'hAB, 32'hCD, 32'hEF, 5'd12, 5'd13, 5'd14, 9'h105, 1'b0, 1'b0);
        #1;
        chk("rel_stall", 32'(bus.stall_out), 32'h0);
        step();
        chk("rel_pc",   bus.ex_pc_plus4, 32'h210);
        chk("rel_rd2",  bus.ex_read_data2, 32'hCD);
        chk("rel_rs",   32'(bus.ex_rs), 32'd12);
        chk("rel_rd",   32'(bus.ex_rd), 32'd14);
        chk("rel_ctrl", 32'(bus.ex_control), 32'h105);
        chk("rel_lu",   32'(bus.load_use_count), 32'd2);
        chk("rel_fl",   32'(bus.flush_count), 32'd2);

        // Load-use counter saturation: 20 more hazards starting from 2
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 32'h300, 32'h0, 32'h0, 32'h0, 5'd1, 5'd5, 5'd0, 9'h027, 1'b0, 1'b0);
            step();
            drive(1'b1, 32'h304, 32'h0, 32'h0, 32'h0, 5'd5, 5'd6, 5'd0, 9'h041, 1'b0, 1'b0);
            step();
        end
        chk("sat_lu",       32'(bus.load_use_count), 32'hF);
        chk("sat_lu_valid", 32'(bus.ex_valid), 32'h0);

        // Flush counter saturation
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 32'h400, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 9'h041, 1'b1, 1'b0);
            step();
        end
        chk("sat_fl",    32'(bus.flush_count), 32'hF);
        chk("sat_fl_lu", 32'(bus.load_use_count), 32'hF);

        // Asynchronous reset mid-stream
        drive(1'b1, 32'h500, 32'h77, 32'h88, 32'h99, 5'd1, 5'd5, 5'd2, 9'h027, 1'b0, 1'b0);
        step();
        chk("pre_rst_valid", 32'(bus.ex_valid), 32'h1);
        drive(1'b1, 32'h504, 32'h0, 32'h0, 32'h0, 5'd5, 5'd6, 5'd7, 9'h041, 1'b0, 1'b0);
        #1;
        chk("pre_rst_stall", 32'(bus.stall_out), 32'h1);
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.ex_valid), 32'h0);
        chk("arst_pc",    bus.ex_pc_plus4, 32'h0);
        chk("arst_rd1",   bus.ex_read_data1, 32'h0);
        chk("arst_ctrl",  32'(bus.ex_control), 32'h0);
        chk("arst_rt",    32'(bus.ex_rt), 32'h0);
        chk("arst_lu",    32'(bus.load_use_count), 32'h0);
        chk("arst_fl",    32'(bus.flush_count), 32'h0);
        chk("arst_stall", 32'(bus.stall_out), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("post_rst_valid", 32'(bus.ex_valid), 32'h1);
        chk("post_rst_pc",    bus.ex_pc_plus4, 32'h504);
        chk("post_rst_ctrl",  32'(bus.ex_control), 32'h041);
        chk("post_rst_lu",    32'(bus.load_use_count), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
